// File: rtl/snoop_agg_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : snoop_agg_pkg
//  Purpose  : Shared types and constants for the snoop line aggregator.
//             Holds the aggregator FSM state encoding and the CRRESP field
//             layout used by the top level.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package snoop_agg_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_DONE = 2'd1,
        STREAM    = 2'd2,
        OUT       = 2'd3
    } agg_state_t;

    // CRRESP[0] (DataTransfer) says whether a line accompanies the response.
    localparam int CRRESP_DATA_TRANSFER_BIT = 0;
    localparam int CRRESP_WIDTH             = 5;

endpackage
`default_nettype wire

// File: rtl/snoop_line_aggregator_start_delay.sv
`default_nettype none
// ============================================================================
//  Module   : snoop_start_delay
//  Purpose  : START_TO_DATA_LAT-deep shift register that delays the start
//             request so that cap_en lines up with the section it asked for.
//  Ports    : ACLK    in   clock
//             ARESET  in   asynchronous active-high reset
//             clr     in   synchronous flush (drops in-flight requests)
//             start   in   section request
//             cap_en  out  start delayed by START_TO_DATA_LAT cycles
//  Revision : 1.0 - initial release
// ============================================================================
module snoop_start_delay #(
    parameter int START_TO_DATA_LAT = 2
) (
    input  logic ACLK,
    input  logic ARESET,
    input  logic clr,
    input  logic start,
    output logic cap_en
);

    logic [START_TO_DATA_LAT-1:0] r_shift;

    generate
        if (START_TO_DATA_LAT == 1) begin : g_lat_one
            always_ff @(posedge ACLK or posedge ARESET) begin
                if (ARESET) begin
                    r_shift <= '0;
                end else if (clr) begin
                    r_shift <= '0;
                end else begin
                    r_shift <= start;
                end
            end
        end else begin : g_lat_multi
            always_ff @(posedge ACLK or posedge ARESET) begin
                if (ARESET) begin
                    r_shift <= '0;
                end else if (clr) begin
                    r_shift <= '0;
                end else begin
                    r_shift <= {r_shift[START_TO_DATA_LAT-2:0], start};
                end
            end
        end
    endgenerate

    assign cap_en = r_shift[START_TO_DATA_LAT-1];

endmodule
`default_nettype wire

// File: rtl/snoop_line_aggregator.sv
`default_nettype none
// ============================================================================
//  Module   : snoop_line_aggregator
//  Purpose  : Waits for a new snoop response from the snoop logic stage,
//             streams the captured cache line out of it one section per
//             cycle using start/stop, reassembles the line and offers it with
//             CRRESP to the interconnect over a valid/ready handshake.
//  Ports    : ACLK, ARESET           clock, async active-high reset
//             crresp_vld, CRRESP_IN  snoop response (level) and its value
//             done_data              stage holds a full line
//             cache_line_section     streamed section
//             abort                  cancel current snoop
//             start, stop            streaming control to the snoop stage
//             line_valid/line_ready  result handshake
//             line_data, line_resp,
//             line_has_data          result payload
//             timeout_err            watchdog fired (SNOOP_AGG_TIMEOUT_EN only)
//             busy                   not IDLE
//  Config   : `define SNOOP_AGG_TIMEOUT_EN adds a WAIT_DONE watchdog and the
//             timeout_err output.
//  Revision : 1.0 - initial release
// ============================================================================
module snoop_line_aggregator
    import snoop_agg_pkg::*;
#(
    parameter int DATA_SIZE         = 128,
    parameter int NUM_BEATS         = 4,
    parameter int START_TO_DATA_LAT = 2,
    parameter int TIMEOUT_CYCLES    = 64
) (
    input  logic                           ACLK,
    input  logic                           ARESET,
    input  logic                           crresp_vld,
    input  logic [CRRESP_WIDTH-1:0]        CRRESP_IN,
    input  logic                           done_data,
    input  logic [DATA_SIZE-1:0]           cache_line_section,
    input  logic                           abort,
    output logic                           start,
    output logic                           stop,
    output logic                           line_valid,
    input  logic                           line_ready,
    output logic [DATA_SIZE*NUM_BEATS-1:0] line_data,
    output logic [CRRESP_WIDTH-1:0]        line_resp,
    output logic                           line_has_data,
`ifdef SNOOP_AGG_TIMEOUT_EN
    output logic                           timeout_err,
`endif
    output logic                           busy
);

    // One extra bit so the counters can reach NUM_BEATS without wrapping.
    localparam int CNT_W = $clog2(NUM_BEATS) + 1;

    agg_state_t                     r_state;
    agg_state_t                     w_state_nxt;
    logic                           r_crresp_vld_q;
    logic                           w_rsp_evt;
    logic [CNT_W-1:0]               r_issue_cnt;
    logic [CNT_W-1:0]               r_cap_cnt;
    logic [DATA_SIZE*NUM_BEATS-1:0] r_line_data;
    logic [CRRESP_WIDTH-1:0]        r_line_resp;
    logic                           r_line_has_data;
    logic                           r_stop;
    logic                           w_start;
    logic                           w_cap_en;
    logic                           w_cap_we;
    logic                           w_cap_last;
    logic                           w_abort_go;
    logic                           w_timeout_go;
    logic                           w_handshake;
    logic                           w_clr;

    // Only the rising edge of the level-type response valid starts a snoop.
    assign w_rsp_evt   = crresp_vld & ~r_crresp_vld_q;
    assign w_abort_go  = abort && ((r_state == WAIT_DONE) || (r_state == STREAM));
    assign w_handshake = (r_state == OUT) && line_ready;
    assign w_clr       = w_abort_go || w_handshake;
    assign w_cap_we    = w_cap_en && (r_state == STREAM);
    assign w_cap_last  = w_cap_we && (r_cap_cnt == CNT_W'(NUM_BEATS - 1));

    snoop_start_delay #(
        .START_TO_DATA_LAT (START_TO_DATA_LAT)
    ) u_start_delay (
        .ACLK   (ACLK),
        .ARESET (ARESET),
        .clr    (w_clr),
        .start  (w_start),
        .cap_en (w_cap_en)
    );

`ifdef SNOOP_AGG_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] r_wd_cnt;
    logic            r_timeout_err;

    // Fires after TIMEOUT_CYCLES cycles in WAIT_DONE; done_data or abort in
    // that same cycle take precedence.
    assign w_timeout_go = (r_state == WAIT_DONE) && !done_data && !abort &&
                          (r_wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_wd_cnt      <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_wd_cnt <= (r_state == WAIT_DONE) ? r_wd_cnt + 1'b1 : '0;
            if (w_timeout_go) begin
                r_timeout_err <= 1'b1;
            end else if (w_handshake) begin
                r_timeout_err <= 1'b0;
            end
        end
    end

    assign timeout_err = r_timeout_err;
`else
    assign w_timeout_go = 1'b0;
`endif

    // State register.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and state-decoded outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        line_valid  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_rsp_evt) begin
                    w_state_nxt = CRRESP_IN[CRRESP_DATA_TRANSFER_BIT] ? WAIT_DONE : OUT;
                end
            end
            WAIT_DONE: begin
                if (abort) begin
                    w_state_nxt = IDLE;
                end else if (done_data) begin
                    w_state_nxt = STREAM;
                end else if (w_timeout_go) begin
                    w_state_nxt = OUT;
                end
            end
            STREAM: begin
                // Held without gaps: the snoop stage restarts its section
                // index whenever start drops.
                w_start = (r_issue_cnt < CNT_W'(NUM_BEATS));
                if (abort) begin
                    w_state_nxt = IDLE;
                end else if (w_cap_last) begin
                    w_state_nxt = OUT;
                end
            end
            OUT: begin
                line_valid = 1'b1;
                if (line_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Control datapath: edge detect, counters, response and stop pulse.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_crresp_vld_q  <= 1'b0;
            r_issue_cnt     <= '0;
            r_cap_cnt       <= '0;
            r_line_resp     <= '0;
            r_line_has_data <= 1'b0;
            r_stop          <= 1'b0;
        end else begin
            r_crresp_vld_q <= crresp_vld;
            r_stop         <= w_abort_go || w_timeout_go;

            if ((r_state == IDLE) && w_rsp_evt) begin
                r_line_resp <= CRRESP_IN;
                if (!CRRESP_IN[CRRESP_DATA_TRANSFER_BIT]) begin
                    r_line_has_data <= 1'b0;
                end
            end

            if (w_start) begin
                r_issue_cnt <= r_issue_cnt + 1'b1;
            end
            if (w_cap_we) begin
                r_cap_cnt <= r_cap_cnt + 1'b1;
            end
            if (w_cap_last) begin
                r_line_has_data <= 1'b1;
            end
            if (w_timeout_go) begin
                r_line_has_data <= 1'b0;
            end

            if (w_clr) begin
                r_issue_cnt <= '0;
                r_cap_cnt   <= '0;
            end
        end
    end

    // Per-section capture registers.
    generate
        for (genvar k = 0; k < NUM_BEATS; k++) begin : g_section
            always_ff @(posedge ACLK or posedge ARESET) begin
                if (ARESET) begin
                    r_line_data[DATA_SIZE*k +: DATA_SIZE] <= '0;
                end else if (w_cap_we && (r_cap_cnt == CNT_W'(k))) begin
                    r_line_data[DATA_SIZE*k +: DATA_SIZE] <= cache_line_section;
                end
            end
        end
    endgenerate

    assign start         = w_start;
    assign stop          = r_stop;
    assign line_data     = r_line_data;
    assign line_resp     = r_line_resp;
    assign line_has_data = r_line_has_data;
    assign busy          = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_snoop_line_aggregator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_snoop_line_aggregator
//  Purpose  : Self-checking bench for snoop_line_aggregator. Includes a small
//             model of the snoop stage that returns section k two cycles
//             after the k-th contiguous start cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_snoop_line_aggregator;

    localparam int DW  = 128;
    localparam int NB  = 4;
    localparam int LAT = 2;
    localparam int LW  = DW * NB;

    logic          ACLK        = 1'b0;
    logic          ARESET      = 1'b1;
    logic          crresp_vld  = 1'b0;
    logic [4:0]    CRRESP_IN   = '0;
    logic          done_data   = 1'b0;
    logic [DW-1:0] cache_line_section = '0;
    logic          abort       = 1'b0;
    logic          line_ready  = 1'b0;
    wire           start;
    wire           stop;
    wire           line_valid;
    wire  [LW-1:0] line_data;
    wire  [4:0]    line_resp;
    wire           line_has_data;
    wire           busy;
`ifdef SNOOP_AGG_TIMEOUT_EN
    wire           timeout_err;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    snoop_line_aggregator #(
        .DATA_SIZE         (DW),
        .NUM_BEATS         (NB),
        .START_TO_DATA_LAT (LAT),
        .TIMEOUT_CYCLES    (8)
    ) dut (
        .ACLK               (ACLK),
        .ARESET             (ARESET),
        .crresp_vld         (crresp_vld),
        .CRRESP_IN          (CRRESP_IN),
        .done_data          (done_data),
        .cache_line_section (cache_line_section),
        .abort              (abort),
        .start              (start),
        .stop               (stop),
        .line_valid         (line_valid),
        .line_ready         (line_ready),
        .line_data          (line_data),
        .line_resp          (line_resp),
        .line_has_data      (line_has_data),
`ifdef SNOOP_AGG_TIMEOUT_EN
        .timeout_err        (timeout_err),
`endif
        .busy               (busy)
    );

    always #5 ACLK = ~ACLK;

    // Snoop stage model: index restarts on any start gap; the section for
    // a start cycle is presented LAT cycles later, junk otherwise.
    logic [LW-1:0] cur_line = '0;
    int            st_idx   = 0;
    logic          p1_v     = 1'b0;
    int            p1_idx   = 0;

    always @(posedge ACLK) begin
        st_idx <= start ? st_idx + 1 : 0;
        p1_v   <= start;
        p1_idx <= st_idx;
        cache_line_section <= (p1_v && p1_idx < NB) ? cur_line[p1_idx*DW +: DW]
                                                     : {4{32'hBAD0_BAD0}};
    end

    task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [4:0]    resp;
        logic [LW-1:0] line;
        int            dd;        // cycles after the event when done_data pulses
        int            hold_rdy;  // cycles line_ready is held low in OUT
        logic          exp_has;
        int            exp_lat;   // cycles from event to line_valid
        int            exp_starts;
    } vec_t;

    vec_t vecs[5];

    // One full snoop: event, optional streaming, backpressure, handshake.
    task automatic do_txn(input vec_t v, input bit keep_vld);
        int   lat    = -1;
        int   starts = 0;
        int   runs   = 0;
        logic prev   = 1'b0;
        logic stable = 1'b1;
        logic [LW-1:0] snap;
        cur_line = v.line;
        @(negedge ACLK);
        CRRESP_IN  = v.resp;
        crresp_vld = 1'b1;
        for (int i = 1; i <= 60; i++) begin
            @(negedge ACLK);
            done_data = (i == v.dd);
            if (start) begin
                starts++;
                if (!prev) runs++;
            end
            prev = start;
            if (line_valid) begin
                lat = i;
                break;
            end
        end
        done_data = 1'b0;
        chk("latency_to_valid", lat, v.exp_lat);
        chk("start_cycles", starts, v.exp_starts);
        if (v.exp_starts > 0) chk("start_contiguous", runs, 1);
        chk("line_resp", line_resp, v.resp);
        chk("line_has_data", line_has_data, v.exp_has);
        if (v.exp_has) chk("line_data", line_data, v.line);
        snap = line_data;
        for (int i = 0; i < v.hold_rdy; i++) begin
            @(negedge ACLK);
            if (!line_valid || line_data !== snap || line_resp !== v.resp ||
                line_has_data !== v.exp_has) stable = 1'b0;
        end
        if (v.hold_rdy > 0) chk("backpressure_stable", stable, 1'b1);
        line_ready = 1'b1;
        @(negedge ACLK);
        line_ready = 1'b0;
        chk("idle_after_handshake", {busy, line_valid}, 2'b00);
        if (!keep_vld) crresp_vld = 1'b0;
    endtask

    initial begin
        int   cnt;
        int   stops;
        logic seen;

        vecs[0] = '{5'b00001, {128'hA3, 128'hA2, 128'hA1, 128'hA0}, 3, 0, 1'b1, 10, 4};
        vecs[1] = '{5'b00100, '0, 3, 0, 1'b0, 1, 0};
        vecs[2] = '{5'b10011, {{4{32'h3333_0003}}, {4{32'h2222_0002}}, {4{32'h1111_0001}}, {4{32'h0000_F00D}}}, 2, 10, 1'b1, 9, 4};
        vecs[3] = '{5'b01000, '0, 5, 3, 1'b0, 1, 0};
        vecs[4] = '{5'b11101, {{2{64'hFEDC_BA98_7654_3210}}, {4{32'h5A5A_A5A5}}, {2{64'h0F0F_F0F0_1234_5678}}, {4{32'hC0DE_0000}}}, 6, 1, 1'b1, 13, 4};

        // Reset state.
        repeat (3) @(negedge ACLK);
        chk("reset_outputs", {start, stop, line_valid, line_data, line_resp, line_has_data, busy}, '0);
        ARESET = 1'b0;
        @(negedge ACLK);

        for (int k = 0; k < 5; k++) do_txn(vecs[k], 1'b0);

        // Level hold: response valid stays high after the handshake.
        do_txn(vecs[1], 1'b1);
        seen = 1'b0;
        repeat (10) begin
            @(negedge ACLK);
            if (line_valid || busy) seen = 1'b1;
        end
        chk("level_hold_no_retrigger", seen, 1'b0);
        crresp_vld = 1'b0;

        // Abort after two start cycles.
        cur_line = vecs[0].line;
        @(negedge ACLK);
        CRRESP_IN  = 5'b00001;
        crresp_vld = 1'b1;
        cnt = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge ACLK);
            done_data = (i == 2);
            if (start) cnt++;
            if (cnt == 2) break;
        end
        done_data = 1'b0;
        chk("abort_start_count", cnt, 2);
        abort = 1'b1;
        @(negedge ACLK);
        abort = 1'b0;
        chk("abort_stop_pulse", {stop, busy, start}, 3'b100);
        @(negedge ACLK);
        chk("abort_stop_one_cycle", stop, 1'b0);
        seen  = 1'b0;
        stops = 0;
        repeat (8) begin
            @(negedge ACLK);
            if (line_valid || start) seen = 1'b1;
            if (stop) stops++;
        end
        chk("abort_no_line_valid", seen, 1'b0);
        chk("abort_no_extra_stop", stops, 0);
        crresp_vld = 1'b0;

        // Recovery after abort.
        do_txn(vecs[2], 1'b0);

        // Abort ignored in OUT.
        cur_line = vecs[0].line;
        @(negedge ACLK);
        CRRESP_IN  = 5'b00110;
        crresp_vld = 1'b1;
        @(negedge ACLK);
        abort = 1'b1;
        @(negedge ACLK);
        abort = 1'b0;
        chk("abort_in_out_ignored", {line_valid, stop, line_resp}, {1'b1, 1'b0, 5'b00110});
        line_ready = 1'b1;
        @(negedge ACLK);
        line_ready = 1'b0;
        crresp_vld = 1'b0;

        // Asynchronous reset while presenting a line.
        cur_line = vecs[0].line;
        @(negedge ACLK);
        CRRESP_IN  = 5'b00001;
        crresp_vld = 1'b1;
        seen = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge ACLK);
            done_data = (i == 2);
            if (line_valid) begin
                seen = 1'b1;
                break;
            end
        end
        done_data = 1'b0;
        chk("areset_reached_out", seen, 1'b1);
        #2;
        ARESET     = 1'b1;
        crresp_vld = 1'b0;
        #1;
        chk("areset_immediate_zero", {start, stop, line_valid, line_data, line_resp, line_has_data, busy}, '0);
        @(negedge ACLK);
        ARESET = 1'b0;
        @(negedge ACLK);
        chk("after_areset_idle", {busy, line_valid}, 2'b00);

`ifdef SNOOP_AGG_TIMEOUT_EN
        // Watchdog with no done_data.
        @(negedge ACLK);
        CRRESP_IN  = 5'b00001;
        crresp_vld = 1'b1;
        seen  = 1'b0;
        stops = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge ACLK);
            if (stop) stops++;
            if (line_valid) begin
                seen = 1'b1;
                break;
            end
        end
        @(negedge ACLK);
        if (stop) stops++;
        chk("timeout_valid", seen, 1'b1);
        chk("timeout_stop_pulses", stops, 1);
        chk("timeout_err_set", {timeout_err, line_has_data}, 2'b10);
        line_ready = 1'b1;
        @(negedge ACLK);
        line_ready = 1'b0;
        crresp_vld = 1'b0;
        chk("timeout_err_clear", {timeout_err, busy}, 2'b00);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got running expected done");
        $fatal(1, "bench timeout");
    end

endmodule
`default_nettype wire

// File: doc/snoop_line_aggregator.md
Name: snoop_line_aggregator

Overview:
- Downstream consumer of the snoop logic stage (ACE snoop channel master side).
- Detects the stage's snoop response, then drives its `start`/`stop` controls to stream out the captured cache line one section per cycle.
- Reassembles the sections into a full line and presents line plus CRRESP to the interconnect over a valid/ready handshake.

Parameters:
- DATA_SIZE, 128, width of one cache line section (CD beat).
- NUM_BEATS, 4, sections per cache line.
- START_TO_DATA_LAT, 2, cycles from `start` high to the matching section being valid on `cache_line_section`.
- TIMEOUT_CYCLES, 64, watchdog limit (used only with the optional feature).

Ports:
- ACLK  in  1  clock
- ARESET  in  1  asynchronous active-high reset
- crresp_vld  in  1  snoop response valid (level, stays high once set)
- CRRESP_IN  in  5  captured snoop response
- done_data  in  1  snoop stage holds a full line ready for streaming
- cache_line_section  in  DATA_SIZE  streamed line section
- abort  in  1  interconnect cancels the current snoop
- start  out  1  request section streaming (held contiguous)
- stop  out  1  one-cycle abort pulse to the snoop stage
- line_valid  out  1  assembled result valid
- line_ready  in  1  interconnect accepts result
- line_data  out  DATA_SIZE*NUM_BEATS  assembled line; section k at bits [DATA_SIZE*(k+1)-1 : DATA_SIZE*k]
- line_resp  out  5  CRRESP for this snoop
- line_has_data  out  1  line_data meaningful (CRRESP[0]=1)
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, ARESET=1): state is IDLE; all counters and internal registers are 0; all outputs are 0 (start, stop, line_valid, line_data, line_resp, line_has_data, busy). Reset mid-operation drops any partial line silently.
- Response event: `rsp_evt = crresp_vld & ~crresp_vld_q`, where `crresp_vld_q` is a registered copy of `crresp_vld`. Only `rsp_evt` is acted on; a level held high does not retrigger.
- IDLE:
  - On `rsp_evt`, latch CRRESP_IN into line_resp.
  - If CRRESP_IN[0]=0: line_has_data<=0 and go to OUT.
  - Otherwise go to WAIT_DONE.
  - done_data seen in IDLE is ignored.
- WAIT_DONE: on done_data=1, go to STREAM.
- STREAM:
  - `start` is 1 for exactly NUM_BEATS consecutive cycles, counted by `issue_cnt` (0..NUM_BEATS-1). It never drops mid-burst, because the snoop stage resets its section index on any gap.
  - A START_TO_DATA_LAT-deep shift register delays `start` to produce `cap_en`.
  - Each `cap_en` cycle writes cache_line_section into section `cap_cnt`, then increments `cap_cnt`.
  - When the NUM_BEATS-th capture occurs: line_has_data<=1 and go to OUT on the next cycle.
  - Total STREAM duration is NUM_BEATS+START_TO_DATA_LAT cycles.
- OUT:
  - line_valid=1. line_data, line_resp and line_has_data stay stable while valid is high and ready is low.
  - On line_valid & line_ready: line_valid<=0, counters clear, go to IDLE.
- abort (any state except IDLE or OUT):
  - stop=1 for exactly one cycle (registered, asserted the cycle after abort is sampled).
  - Go to IDLE; line_valid never rises for that snoop.
- abort in OUT: ignored; the handshake completes normally.
- abort in IDLE: ignored.
- Widths: issue_cnt and cap_cnt are $clog2(NUM_BEATS)+1 bits, so NUM_BEATS=4 has no wrap ambiguity. The shift register is START_TO_DATA_LAT bits.

Optional Feature:
- Macro: SNOOP_AGG_TIMEOUT_EN.
- With the macro:
  - A watchdog counts cycles spent in WAIT_DONE.
  - On reaching TIMEOUT_CYCLES it pulses stop for 1 cycle and goes to OUT with line_has_data=0 and line_resp[4]... left as latched.
  - Adds output port `timeout_err` (1 bit), which is set with that OUT and cleared on the handshake.
- Without the macro: no counter and no port; WAIT_DONE waits indefinitely.

Decomposition:
- Package snoop_agg_pkg:
  - state enum {IDLE, WAIT_DONE, STREAM, OUT}.
  - localparams CRRESP_DATA_TRANSFER_BIT=0 and CRRESP_WIDTH=5.
- One natural sub-module: snoop_start_delay, a parameterized START_TO_DATA_LAT-deep shift register producing cap_en.

Test Plan:
- Data path:
  - Stimulus: crresp_vld rises with CRRESP_IN=5'b00001; done_data 3 cycles later; sections 'hA0..'hA3 arrive at lat 2.
  - Required: start high exactly 4 cycles; line_valid with line_data={A3,A2,A1,A0}, line_resp=1, line_has_data=1.
- No data:
  - Stimulus: CRRESP_IN=5'b00100.
  - Required: line_valid the cycle after the event; line_has_data=0; start never asserted.
- Backpressure:
  - Stimulus: line_ready held low 10 cycles.
  - Required: line_valid and line_data stable throughout; IDLE one cycle after ready.
- Level hold:
  - Stimulus: crresp_vld stays high after the handshake.
  - Required: no second line_valid.
- Abort in STREAM:
  - Stimulus: abort after 2 start cycles.
  - Required: one-cycle stop pulse; line_valid stays 0; busy=0 the next cycle.
- Async reset:
  - Stimulus: ARESET asserted between clock edges in OUT.
  - Required: all outputs 0 immediately, without waiting for a clock edge.
  - With SNOOP_AGG_TIMEOUT_EN and TIMEOUT_CYCLES=8, no done_data: stop pulse and timeout_err=1.
